// File: rtl/dm_pkg.sv
// dm_pkg: shared types, constants and helpers for the data-memory responder.
//   dm_state_t    : responder FSM state (IDLE, WAIT).
//   DM_WORD_BYTES : bytes per memory word.
//   dm_legal()    : alignment and range check for a core byte address.
package dm_pkg;

    typedef enum logic {IDLE, WAIT} dm_state_t;

    localparam int unsigned DM_WORD_BYTES = 4;

    // Legal means word aligned and inside the window [base, base + depth*4).
    // The offset wraps, so an address below base yields a huge offset and is
    // rejected. The limit is compared at 34 bits so depth*4 cannot overflow.
    function automatic logic dm_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth);
        logic [31:0] off;
        logic [33:0] lim;
        off = addr - base;
        lim = 34'(depth) * 34'(DM_WORD_BYTES);
        return (addr[1:0] == 2'b00) && ({2'b00, off} < lim);
    endfunction

endpackage

// File: rtl/sram_1rw.sv
// sram_1rw: single-port synchronous SRAM, no reset on the array.
//   clk   in  clock
//   en    in  access enable
//   we    in  1 = write wdata to addr, 0 = read addr into rdata
//   addr  in  word index
//   wdata in  write data
//   rdata out registered read data; changes only on a read access
module sram_1rw #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: wait-state data-memory responder for the core DM port.
//   clk, rst    in  clock; synchronous active-high reset
//   DM_address  in  byte address from the core
//   DM_in       in  write data
//   DM_enable   in  access request, held by the core while stall=1
//   DM_write    in  1 = write, 0 = read
//   DM_out      out read data, valid in the release cycle, holds between accesses
//   stall       out freezes the core pipeline during the access
//   err         out sticky illegal-access flag
//   err_addr    out address of the first illegal access
// Each access stalls WAIT_CYCLES cycles (1..15) and releases on the next one.
module dm_responder
    import dm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DM_address,
    input  logic [31:0] DM_in,
    input  logic        DM_enable,
    input  logic        DM_write,
    output logic [31:0] DM_out,
    output logic        stall,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);

    dm_state_t   state;
    logic [3:0]  cnt;
    logic        legal;
    logic        accept;
    logic [AW-1:0] idx;
    logic [31:0] ram_rdata;
    // Forces DM_out to zero after reset or an illegal read; cleared by the
    // next legal read. Together with the SRAM output register this behaves
    // as a single read-data register that resets to 0 and loads 0 on error.
    logic        zero_q;

    assign legal  = dm_legal(DM_address, BASE_ADDR, DEPTH_WORDS);
    assign idx    = AW'((DM_address - BASE_ADDR) >> 2);
    // Reset wins over a simultaneous request: nothing reaches the array.
    assign accept = (state == IDLE) && DM_enable && !rst;

    sram_1rw #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (32)
    ) u_sram (
        .clk   (clk),
        .en    (accept && legal),
        .we    (DM_write),
        .addr  (idx),
        .wdata (DM_in),
        .rdata (ram_rdata)
    );

    assign DM_out = zero_q ? '0 : ram_rdata;

    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE: stall = DM_enable;
            WAIT: stall = (cnt != 4'd0);
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            zero_q   <= 1'b1;
            err      <= 1'b0;
            err_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (DM_enable) begin
                        state <= WAIT;
                        cnt   <= CNT_LOAD;
                        if (!DM_write) begin
                            zero_q <= !legal;
                        end
                        if (!legal && !err) begin
                            err      <= 1'b1;
                            err_addr <= DM_address;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Wait-state data-memory responder serving the CPU core's DM port (`DM_address`/`DM_in`/`DM_enable`/`DM_write` in, `DM_out` out). It holds a word-addressed synchronous SRAM array and inserts a fixed number of wait states per access by driving `stall`. The top level ORs this `stall` with any other stall sources before it reaches the core. It also records the first illegal access in sticky error registers.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of 2.
- `WAIT_CYCLES`, 2: stall cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `DM_address`  in  32  byte address from the core.
- `DM_in`  in  32  write data.
- `DM_enable`  in  1  access request; held stable by the core while `stall`=1.
- `DM_write`  in  1  1 = write, 0 = read.
- `DM_out`  out  32  read data; valid in the release cycle.
- `stall`  out  1  freezes the core pipeline.
- `err`  out  1  sticky illegal-access flag.
- `err_addr`  out  32  address of the first illegal access.

## Operation
- FSM states: IDLE, WAIT.
- **IDLE with `DM_enable`=1 (acceptance cycle A):**
  - `stall`=1, driven combinationally.
  - At the closing edge: perform the array op, load `cnt` <= `WAIT_CYCLES`-1, go to WAIT.
- **IDLE with `DM_enable`=0:** `stall`=0. No state change.
- **WAIT with `cnt`!=0:** `stall`=1, `cnt` decrements.
- **WAIT with `cnt`==0 (release cycle):** `stall`=0, `DM_out` is valid, next state is IDLE.
- **Array op at the acceptance edge:**
  - Write: `mem[idx]` <= `DM_in`. `DM_out` register unchanged.
  - Read: `rdata_q` <= `mem[idx]`. Synchronous read.
  - `idx` = (`DM_address`-`BASE_ADDR`)[2 +: log2(`DEPTH_WORDS`)].
- **Legal access:** `DM_address`[1:0]==0 and (`DM_address`-`BASE_ADDR`) < `DEPTH_WORDS`*4. The subtraction is unsigned, 32-bit, and wraps, so addresses below `BASE_ADDR` are illegal.
- **Illegal access:**
  - Write is suppressed; a read loads `rdata_q` <= 0.
  - Wait-state timing is identical to a legal access.
  - If `err`==0: `err` <= 1 and `err_addr` <= `DM_address`. Later errors do not overwrite.
- `DM_out` = `rdata_q` at all times; it holds its last value between accesses.
- `DM_enable` is ignored while in WAIT; the request is assumed held, not re-sampled.

## Timing
- Each access occupies `WAIT_CYCLES`+1 cycles:
  - `stall`=1 for cycles A .. A+`WAIT_CYCLES`-1.
  - Release in cycle A+`WAIT_CYCLES`; the core captures `DM_out` at that edge.
- Back-to-back accesses: the next request can be accepted at A+`WAIT_CYCLES`+1 at the earliest. No idle bubble beyond this.
- Read-after-write to the same word returns the new data.
- Reset values:
  - state = IDLE, `cnt` = 0, `stall` = 0.
  - `rdata_q`/`DM_out` = 0, `err` = 0, `err_addr` = 0.
  - Array contents are not cleared.
- Reset during WAIT:
  - Next cycle is IDLE with `stall`=0.
  - A write already committed at the acceptance edge remains in the array.
  - The in-flight read result is discarded (`DM_out`=0).
- `rst` with `DM_enable` in the same cycle: reset wins, nothing is accepted, and the request is re-accepted in the first cycle after reset.

## Structure
- Shared package `dm_pkg`:
  - `typedef enum logic {IDLE, WAIT} dm_state_t`.
  - `DM_WORD_BYTES` = 4.
  - Function `dm_legal(addr, base, depth)`.
- One sub-module `sram_1rw` (parameterised depth/width, single port, sync write, sync read, no reset on the array). Responder FSM, counter, range check and error logic live in `dm_responder`.

## Test plan
1. **Write then read.** Sequence:
   - Reset, `WAIT_CYCLES`=2.
   - Write 32'hDEADBEEF to `BASE_ADDR`+8, holding the request while stalled.
   - Read the same address.
   - Required: `stall` high for exactly 2 cycles per access; `DM_out`=32'hDEADBEEF in the read release cycle.
2. **Back-to-back reads.** Preload words 0..3 with 0x11,0x22,0x33,0x44; issue 4 consecutive reads, with `DM_enable` kept high and the address advanced at each release. Required: `DM_out` sequence 0x11,0x22,0x33,0x44; release cycles spaced exactly 3 cycles apart.
3. **Illegal accesses.**
   - Write to `BASE_ADDR`+`DEPTH_WORDS`*4 (out of range): array unchanged; `err`=1, `err_addr`=that address.
   - Then a misaligned read at 0x6: `DM_out`=0, `err_addr` unchanged, stall timing still 2 cycles.
4. **Reset mid-operation.** Assert `rst` in the second stall cycle of a read. Required: `stall`=0 and `DM_out`=0 the next cycle; a fresh read of the same word then completes normally.
5. **Parameter sweep.** `WAIT_CYCLES`=1 and 15. Required: stall lengths of 1 and 15 cycles; data correct; reads with `DM_enable` low generate no stall.
6. **Address wrap.** `BASE_ADDR`=32'h0000_1000, access 32'h0000_0FFC. Required: flagged illegal (unsigned wrap), write dropped.
